// File: rtl/hazard_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit_pkg
// Shared types for the pipeline hazard controller.
//   hcu_state_e : controller FSM state (RUN / PEND)
//   JUMP_NONE   : EX_JumpOP value meaning "no taken jump or branch in EX"
//   hcu_ctrl_t  : bundle of per-register hold/flush controls
// ---------------------------------------------------------------------------
package hazard_ctrl_unit_pkg;

  // PEND: a jump resolved during an I-cache miss and its flush is still owed
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } hcu_state_e;

  localparam logic [1:0] JUMP_NONE = 2'b00;

  typedef struct packed {
    logic pcHold;
    logic ifidHold;
    logic idexHold;
    logic exmHold;
    logic mwbHold;
    logic ifFlush;
    logic idFlush;
  } hcu_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit_if
// Bundles the pipeline-side signals of the hazard controller.
//   Inputs to the controller : ID_Rs, ID_Rt, ID_UseRt, EX_WR_out, MEM_WR_out,
//                              EX_MemtoReg, MEM_MemtoReg, EX_JumpOP,
//                              IC_Stall, DC_Stall, Cnt_Clr
//   Outputs of the controller: PCWrite, IFIDWrite, IDEXWrite, EXMWrite,
//                              MWBWrite, IFFlush, IDFlush, RedirectPend,
//                              LU_Cnt, CS_Cnt, FL_Cnt
//   modport slave  : the hazard controller itself
//   modport master : the pipeline that feeds it and consumes its controls
// ---------------------------------------------------------------------------
interface hazard_ctrl_unit_if #(
  parameter int REG_W   = 5,
  parameter int COUNT_W = 32
);

  logic [REG_W-1:0]   ID_Rs;
  logic [REG_W-1:0]   ID_Rt;
  logic               ID_UseRt;
  logic [REG_W-1:0]   EX_WR_out;
  logic [REG_W-1:0]   MEM_WR_out;
  logic               EX_MemtoReg;
  logic               MEM_MemtoReg;
  logic [1:0]         EX_JumpOP;
  logic               IC_Stall;
  logic               DC_Stall;
  logic               Cnt_Clr;

  logic               PCWrite;
  logic               IFIDWrite;
  logic               IDEXWrite;
  logic               EXMWrite;
  logic               MWBWrite;
  logic               IFFlush;
  logic               IDFlush;
  logic               RedirectPend;
  logic [COUNT_W-1:0] LU_Cnt;
  logic [COUNT_W-1:0] CS_Cnt;
  logic [COUNT_W-1:0] FL_Cnt;

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRt, EX_WR_out, MEM_WR_out,
           EX_MemtoReg, MEM_MemtoReg, EX_JumpOP, IC_Stall, DC_Stall, Cnt_Clr,
    output PCWrite, IFIDWrite, IDEXWrite, EXMWrite, MWBWrite,
           IFFlush, IDFlush, RedirectPend, LU_Cnt, CS_Cnt, FL_Cnt
  );

  modport master (
    output ID_Rs, ID_Rt, ID_UseRt, EX_WR_out, MEM_WR_out,
           EX_MemtoReg, MEM_MemtoReg, EX_JumpOP, IC_Stall, DC_Stall, Cnt_Clr,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMWrite, MWBWrite,
           IFFlush, IDFlush, RedirectPend, LU_Cnt, CS_Cnt, FL_Cnt
  );

endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   clr   : synchronous clear, wins over inc
//   count : current count value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
// Pipeline hazard controller for the 5-stage core. Merges load-use detection,
// I-/D-cache miss stalls and EX-stage jump flushes into hold/flush controls
// for the PC and the pipeline registers, remembers a jump resolved during an
// I-cache miss, and counts stall/flush events.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   hif : hazard_ctrl_unit_if.slave carrying all pipeline-side signals
// Parameters: REG_W register-address width, LOAD_LAT load-use distance (1 or
// 2), COUNT_W performance-counter width.
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int COUNT_W  = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_ctrl_unit_if.slave hif
);

  localparam logic [REG_W-1:0] RegZero  = '0;
  localparam bit               CheckMem = (LOAD_LAT >= 2);

  hcu_state_e state_q;
  hcu_state_e state_d;
  hcu_ctrl_t  ctrl;
  logic       luEx;
  logic       luMem;
  logic       luHazard;
  logic       jumpEx;
  logic       incLu;
  logic       incCs;
  logic       incFl;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  // The MEM-stage check only matters when loads take two cycles to return.
  always_comb begin
    luEx = hif.EX_MemtoReg && (hif.EX_WR_out != RegZero) &&
           ((hif.EX_WR_out == hif.ID_Rs) ||
            (hif.ID_UseRt && (hif.EX_WR_out == hif.ID_Rt)));
    luMem = CheckMem && hif.MEM_MemtoReg && (hif.MEM_WR_out != RegZero) &&
            ((hif.MEM_WR_out == hif.ID_Rs) ||
             (hif.ID_UseRt && (hif.MEM_WR_out == hif.ID_Rt)));
    luHazard = luEx || luMem;
    jumpEx   = (hif.EX_JumpOP != JUMP_NONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A D-cache stall freezes everything including the FSM. A jump seen during
  // an I-cache miss is parked in PEND; its flush is issued once both stalls
  // are gone, and further jumps while parked are ignored.
  always_comb begin
    state_d = state_q;
    if (hif.DC_Stall) begin
      state_d = state_q;
    end else if (hif.IC_Stall) begin
      if ((state_q == RUN) && jumpEx) begin
        state_d = PEND;
      end
    end else if (state_q == PEND) begin
      state_d = RUN;
    end
  end

  // Strict priority: D-cache stall, I-cache stall, owed flush, jump, load-use.
  always_comb begin
    ctrl  = '0;
    incLu = 1'b0;
    incCs = 1'b0;
    incFl = 1'b0;
    if (hif.DC_Stall) begin
      ctrl.pcHold   = 1'b1;
      ctrl.ifidHold = 1'b1;
      ctrl.idexHold = 1'b1;
      ctrl.exmHold  = 1'b1;
      ctrl.mwbHold  = 1'b1;
      incCs         = 1'b1;
    end else if (hif.IC_Stall) begin
      ctrl.pcHold   = 1'b1;
      ctrl.ifidHold = 1'b1;
      ctrl.idFlush  = 1'b1;
      incCs         = 1'b1;
    end else if (state_q == PEND) begin
      ctrl.ifFlush  = 1'b1;
      ctrl.idFlush  = 1'b1;
      incFl         = 1'b1;
    end else if (jumpEx) begin
      ctrl.ifFlush  = 1'b1;
      ctrl.idFlush  = 1'b1;
      incFl         = 1'b1;
    end else if (luHazard) begin
      ctrl.pcHold   = 1'b1;
      ctrl.ifidHold = 1'b1;
      ctrl.idFlush  = 1'b1;
      incLu         = 1'b1;
    end
  end

  // Controls are forced low while reset is asserted.
  assign hif.PCWrite      = rst & ctrl.pcHold;
  assign hif.IFIDWrite    = rst & ctrl.ifidHold;
  assign hif.IDEXWrite    = rst & ctrl.idexHold;
  assign hif.EXMWrite     = rst & ctrl.exmHold;
  assign hif.MWBWrite     = rst & ctrl.mwbHold;
  assign hif.IFFlush      = rst & ctrl.ifFlush;
  assign hif.IDFlush      = rst & ctrl.idFlush;
  assign hif.RedirectPend = rst & (state_q == PEND);

  sat_counter #(.COUNT_W(COUNT_W)) uLuCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (incLu),
    .clr   (hif.Cnt_Clr),
    .count (hif.LU_Cnt)
  );

  sat_counter #(.COUNT_W(COUNT_W)) uCsCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (incCs),
    .clr   (hif.Cnt_Clr),
    .count (hif.CS_Cnt)
  );

  sat_counter #(.COUNT_W(COUNT_W)) uFlCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (incFl),
    .clr   (hif.Cnt_Clr),
    .count (hif.FL_Cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit
// Drives two controllers side by side with identical pipeline inputs:
//   dut1 : LOAD_LAT=1, COUNT_W=32
//   dut2 : LOAD_LAT=2, COUNT_W=4 (small counters so saturation is reachable)
// Control outputs are packed as
//   {PCWrite, IFIDWrite, IDEXWrite, EXMWrite, MWBWrite, IFFlush, IDFlush,
//    RedirectPend}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRt;
    logic [4:0] exWr;
    logic [4:0] memWr;
    logic       exLd;
    logic       memLd;
    logic [1:0] jmp;
    logic       ic;
    logic       dc;
    logic       clr;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  cur;

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_W(5), .COUNT_W(32)) hif1 ();
  hazard_ctrl_unit_if #(.REG_W(5), .COUNT_W(4))  hif2 ();

  hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(1), .COUNT_W(32)) dut1 (
    .clk (clk),
    .rst (rst),
    .hif (hif1)
  );

  hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(2), .COUNT_W(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .hif (hif2)
  );

  // Both controllers see the same pipeline inputs
  assign hif1.ID_Rs        = cur.rs;
  assign hif1.ID_Rt        = cur.rt;
  assign hif1.ID_UseRt     = cur.useRt;
  assign hif1.EX_WR_out    = cur.exWr;
  assign hif1.MEM_WR_out   = cur.memWr;
  assign hif1.EX_MemtoReg  = cur.exLd;
  assign hif1.MEM_MemtoReg = cur.memLd;
  assign hif1.EX_JumpOP    = cur.jmp;
  assign hif1.IC_Stall     = cur.ic;
  assign hif1.DC_Stall     = cur.dc;
  assign hif1.Cnt_Clr      = cur.clr;
  assign hif2.ID_Rs        = cur.rs;
  assign hif2.ID_Rt        = cur.rt;
  assign hif2.ID_UseRt     = cur.useRt;
  assign hif2.EX_WR_out    = cur.exWr;
  assign hif2.MEM_WR_out   = cur.memWr;
  assign hif2.EX_MemtoReg  = cur.exLd;
  assign hif2.MEM_MemtoReg = cur.memLd;
  assign hif2.EX_JumpOP    = cur.jmp;
  assign hif2.IC_Stall     = cur.ic;
  assign hif2.DC_Stall     = cur.dc;
  assign hif2.Cnt_Clr      = cur.clr;

  wire [7:0] act1 = {hif1.PCWrite, hif1.IFIDWrite, hif1.IDEXWrite, hif1.EXMWrite,
                     hif1.MWBWrite, hif1.IFFlush, hif1.IDFlush, hif1.RedirectPend};
  wire [7:0] act2 = {hif2.PCWrite, hif2.IFIDWrite, hif2.IDEXWrite, hif2.EXMWrite,
                     hif2.MWBWrite, hif2.IFFlush, hif2.IDFlush, hif2.RedirectPend};

  // Reference state: pending-flush flag and counter values per controller
  bit     mPend [2];
  longint mLu   [2];
  longint mCs   [2];
  longint mFl   [2];
  longint mMax  [2];

  int vectors     = 0;
  int miscompares = 0;

  function automatic in_t mk(input int rs, input int rt, input int useRt,
                             input int exWr, input int memWr, input int exLd,
                             input int memLd, input int jmp, input int ic,
                             input int dc);
    in_t v;
    v.rs    = 5'(rs);
    v.rt    = 5'(rt);
    v.useRt = 1'(useRt);
    v.exWr  = 5'(exWr);
    v.memWr = 5'(memWr);
    v.exLd  = 1'(exLd);
    v.memLd = 1'(memLd);
    v.jmp   = 2'(jmp);
    v.ic    = 1'(ic);
    v.dc    = 1'(dc);
    v.clr   = 1'b0;
    return v;
  endfunction

  function automatic bit ldHit(input logic ld, input logic [4:0] wr, input in_t v);
    return ld && (wr != 5'd0) && ((wr == v.rs) || (v.useRt && (wr == v.rt)));
  endfunction

  // Behavioural view of the controller: outputs and next pending flag from
  // the ranked rule list, plus which counter sees an event this cycle.
  function automatic void refModel(input in_t v, input bit pend, input int lat,
                                   output logic [7:0] ctrl, output bit npend,
                                   output bit iLu, output bit iCs, output bit iFl);
    bit lu;
    lu    = ldHit(v.exLd, v.exWr, v) || ((lat == 2) && ldHit(v.memLd, v.memWr, v));
    ctrl  = 8'h00;
    npend = pend;
    iLu   = 1'b0;
    iCs   = 1'b0;
    iFl   = 1'b0;
    if (v.dc) begin
      ctrl = 8'hF8;
      iCs  = 1'b1;
    end else if (v.ic) begin
      ctrl = 8'hC2;
      iCs  = 1'b1;
      if (!pend && (v.jmp != 2'b00)) npend = 1'b1;
    end else if (pend) begin
      ctrl  = 8'h06;
      iFl   = 1'b1;
      npend = 1'b0;
    end else if (v.jmp != 2'b00) begin
      ctrl = 8'h06;
      iFl  = 1'b1;
    end else if (lu) begin
      ctrl = 8'hC2;
      iLu  = 1'b1;
    end
    ctrl[0] = pend;
  endfunction

  function automatic longint nextCnt(input longint c, input bit inc,
                                     input bit clr, input longint maxV);
    if (clr) return 0;
    if (inc && (c < maxV)) return c + 1;
    return c;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkCnt(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Counter values of both controllers against the reference
  task automatic checkOutput();
    checkCnt("lu_cnt1", longint'(hif1.LU_Cnt), mLu[0]);
    checkCnt("cs_cnt1", longint'(hif1.CS_Cnt), mCs[0]);
    checkCnt("fl_cnt1", longint'(hif1.FL_Cnt), mFl[0]);
    checkCnt("lu_cnt2", longint'(hif2.LU_Cnt), mLu[1]);
    checkCnt("cs_cnt2", longint'(hif2.CS_Cnt), mCs[1]);
    checkCnt("fl_cnt2", longint'(hif2.FL_Cnt), mFl[1]);
  endtask

  // One clock cycle: drive on the falling edge, compare the combinational
  // controls against the model (and the optional hand-written expectation),
  // then advance the model across the rising edge and compare the counters.
  task automatic applyStimulus(input in_t v, input bit chk,
                               input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] mc;
    bit         np [2];
    bit         a, b, c;
    @(negedge clk);
    cur = v;
    #1;
    for (int d = 0; d < 2; d++) begin
      refModel(v, mPend[d], d + 1, mc, np[d], a, b, c);
      check8(d == 0 ? "ctrl_model1" : "ctrl_model2", d == 0 ? act1 : act2, mc);
      mLu[d] = nextCnt(mLu[d], a, v.clr, mMax[d]);
      mCs[d] = nextCnt(mCs[d], b, v.clr, mMax[d]);
      mFl[d] = nextCnt(mFl[d], c, v.clr, mMax[d]);
    end
    if (chk) begin
      check8("ctrl_exp1", act1, e1);
      check8("ctrl_exp2", act2, e2);
    end
    @(posedge clk);
    #1;
    mPend[0] = np[0];
    mPend[1] = np[1];
    checkOutput();
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mPend[d] = 1'b0;
      mLu[d]   = 0;
      mCs[d]   = 0;
      mFl[d]   = 0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [12];
    in_t  idle;
    in_t  v;

    mMax[0] = 64'h0000_0000_FFFF_FFFF;
    mMax[1] = 15;
    modelReset();

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rs rt useRt exWr memWr exLd memLd jmp ic dc
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 8'h00, 8'h00};
    tbl[1]  = '{mk(5, 0, 0, 5, 0, 1, 0, 0, 0, 0), 8'hC2, 8'hC2};
    tbl[2]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 8'h00, 8'h00};
    tbl[3]  = '{mk(1, 7, 1, 7, 0, 1, 0, 0, 0, 0), 8'hC2, 8'hC2};
    tbl[4]  = '{mk(1, 7, 0, 7, 0, 1, 0, 0, 0, 0), 8'h00, 8'h00};
    tbl[5]  = '{mk(5, 0, 0, 0, 5, 0, 1, 0, 0, 0), 8'h00, 8'hC2};
    tbl[6]  = '{mk(1, 6, 0, 0, 6, 0, 1, 0, 0, 0), 8'h00, 8'h00};
    tbl[7]  = '{mk(5, 0, 0, 5, 0, 1, 0, 1, 0, 0), 8'h06, 8'h06};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 8'hF8, 8'hF8};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 8'hC2, 8'hC2};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 8'h00, 8'h00};
    tbl[11] = '{mk(5, 0, 0, 5, 0, 0, 0, 0, 0, 0), 8'h00, 8'h00};

    // Reset: controls low even with a stall requested, counters zero
    cur = idle;
    rst = 1'b0;
    #2;
    check8("reset_ctrl1", act1, 8'h00);
    check8("reset_ctrl2", act2, 8'h00);
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check8("reset_dc_ctrl1", act1, 8'h00);
    check8("reset_dc_ctrl2", act2, 8'h00);
    checkOutput();
    cur = idle;
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].in, 1'b1, tbl[i].exp1, tbl[i].exp2);
    end

    $display("[TB] load-use bubbles");
    v = idle; v.clr = 1'b1;
    applyStimulus(v, 1'b0, 8'h00, 8'h00);
    applyStimulus(mk(5, 0, 0, 5, 0, 1, 0, 0, 0, 0), 1'b1, 8'hC2, 8'hC2);
    applyStimulus(mk(5, 0, 0, 0, 5, 0, 1, 0, 0, 0), 1'b1, 8'h00, 8'hC2);
    applyStimulus(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'h00, 8'h00);
    checkCnt("lu_bubbles1", longint'(hif1.LU_Cnt), 1);
    checkCnt("lu_bubbles2", longint'(hif2.LU_Cnt), 2);

    $display("[TB] jump beats load-use");
    v = idle; v.clr = 1'b1;
    applyStimulus(v, 1'b0, 8'h00, 8'h00);
    applyStimulus(mk(5, 0, 0, 5, 0, 1, 0, 1, 0, 0), 1'b1, 8'h06, 8'h06);
    checkCnt("jump_lu_fl", longint'(hif1.FL_Cnt), 1);
    checkCnt("jump_lu_lu", longint'(hif1.LU_Cnt), 0);

    $display("[TB] jump during I-cache miss");
    v = idle; v.clr = 1'b1;
    applyStimulus(v, 1'b0, 8'h00, 8'h00);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b1, 8'hC2, 8'hC2);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, 8'hC3, 8'hC3);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0), 1'b1, 8'hC3, 8'hC3);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, 8'hC3, 8'hC3);
    applyStimulus(idle, 1'b1, 8'h07, 8'h07);
    applyStimulus(idle, 1'b1, 8'h00, 8'h00);
    checkCnt("ic_cs_cnt", longint'(hif1.CS_Cnt), 4);
    checkCnt("ic_fl_cnt", longint'(hif1.FL_Cnt), 1);

    $display("[TB] D-cache stall over pending redirect");
    v = idle; v.clr = 1'b1;
    applyStimulus(v, 1'b0, 8'h00, 8'h00);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0), 1'b1, 8'hC2, 8'hC2);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b1, 8'hF9, 8'hF9);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 8'hF9, 8'hF9);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 8'hF9, 8'hF9);
    applyStimulus(idle, 1'b1, 8'h07, 8'h07);
    applyStimulus(idle, 1'b1, 8'h00, 8'h00);
    checkCnt("dc_cs_cnt", longint'(hif1.CS_Cnt), 4);

    $display("[TB] reset while pending");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b1, 8'hC2, 8'hC2);
    @(negedge clk);
    cur = idle;
    #1;
    check8("pend_before_rst1", act1, 8'h07);
    rst = 1'b0;
    #1;
    modelReset();
    check8("pend_in_rst1", act1, 8'h00);
    check8("pend_in_rst2", act2, 8'h00);
    checkCnt("rst_cs_cnt1", longint'(hif1.CS_Cnt), 0);
    checkCnt("rst_fl_cnt1", longint'(hif1.FL_Cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(idle, 1'b1, 8'h00, 8'h00);

    $display("[TB] saturation and clear");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 8'h00, 8'h00);
    end
    checkCnt("sat_cs_cnt2", longint'(hif2.CS_Cnt), 15);
    checkCnt("sat_cs_cnt1", longint'(hif1.CS_Cnt), 18);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); v.clr = 1'b1;
    applyStimulus(v, 1'b1, 8'hF8, 8'hF8);
    checkCnt("clr_cs_cnt2", longint'(hif2.CS_Cnt), 0);
    checkCnt("clr_cs_cnt1", longint'(hif1.CS_Cnt), 0);

    $display("[TB] random stimulus");
    for (int i = 0; i < 400; i++) begin
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      v.useRt = 1'($urandom_range(0, 1));
      v.exWr  = 5'($urandom_range(0, 3));
      v.memWr = 5'($urandom_range(0, 3));
      v.exLd  = 1'($urandom_range(0, 1));
      v.memLd = 1'($urandom_range(0, 1));
      v.jmp   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.ic    = ($urandom_range(0, 4) == 0);
      v.dc    = ($urandom_range(0, 6) == 0);
      v.clr   = ($urandom_range(0, 40) == 0);
      applyStimulus(v, 1'b0, 8'h00, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
